// File: rtl/dmem_pipe.sv
// Pipelined byte-addressable data memory: valid/ready requests, fixed read latency, in-order response queue.
// Define DMEM_ALIGN_TRAP_EN to report misaligned halfword/word accesses as errors instead of aligning them.
module dmem_pipe #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_is_store
);
  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef struct packed {
    logic       valid;
    logic       is_store;
    logic       err;
    logic [1:0] size;
    logic       sext;
    logic [1:0] lane;
  } meta_t;

  logic             run_reg;
  logic [CNT_W-1:0] outstanding_reg;
  logic             accept;
  logic             pop;

  logic              out_of_range;
  logic              misaligned;
  logic              req_err;
  logic [ADDR_W-1:0] eff_addr;
  logic [1:0]        lane;
  logic [ADDR_W-3:0] word_idx;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_sh;
  logic              wr_en;
  meta_t             new_meta;

  assign req_ready = run_reg && (outstanding_reg < CNT_W'(MAX_OUT));
  assign accept    = req_valid && req_ready;
  assign pop       = resp_valid && resp_ready;

  always_comb begin
    out_of_range = |(req_addr >> ADDR_W);
    misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    eff_addr     = req_addr[ADDR_W-1:0];
`ifdef DMEM_ALIGN_TRAP_EN
    req_err = out_of_range || misaligned;
`else
    req_err = out_of_range;
    if (misaligned) eff_addr[1:0] = req_size[1] ? 2'b00 : {eff_addr[1], 1'b0};
`endif
    lane     = eff_addr[1:0];
    word_idx = eff_addr[ADDR_W-1:2];
    case (req_size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
    wdata_sh = req_wdata << {lane, 3'b000};
    wr_en    = accept && req_we && !req_err;
    new_meta = '{valid: accept, is_store: req_we, err: req_err,
                 size: req_size, sext: req_sext, lane: lane};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_reg         <= 1'b0;
      outstanding_reg <= '0;
    end else begin
      run_reg <= 1'b1;
      case ({accept, pop})
        2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // One byte-wide bank per lane; read-first so a load sees the array as of its acceptance edge.
  logic [3:0][7:0] rd_bytes;
  meta_t           stage_meta [LATENCY];
  logic [31:0]     stage_data [LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] lane_rd_reg;
      always_ff @(posedge CLK) begin
        if (wr_en && byte_en[gi]) lane_mem[word_idx] <= wdata_sh[gi*8 +: 8];
        lane_rd_reg <= lane_mem[word_idx];
      end
      assign rd_bytes[gi] = lane_rd_reg;
    end

    assign stage_data[0] = rd_bytes;

    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      meta_t meta_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) meta_reg <= '0;
          else     meta_reg <= new_meta;
        end
      end else begin : g_body
        logic [31:0] data_reg;
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) meta_reg <= '0;
          else     meta_reg <= stage_meta[gi-1];
        end
        always_ff @(posedge CLK) data_reg <= stage_data[gi-1];
        assign stage_data[gi] = data_reg;
      end
      assign stage_meta[gi] = meta_reg;
    end
  endgenerate

  meta_t       tail_meta;
  logic [31:0] tail_shift;
  logic [31:0] push_data;
  logic        push;

  always_comb begin
    tail_meta  = stage_meta[LATENCY-1];
    tail_shift = stage_data[LATENCY-1] >> {tail_meta.lane, 3'b000};
    case (tail_meta.size)
      2'b00:   push_data = {{24{tail_meta.sext & tail_shift[7]}}, tail_shift[7:0]};
      2'b01:   push_data = {{16{tail_meta.sext & tail_shift[15]}}, tail_shift[15:0]};
      default: push_data = tail_shift;
    endcase
    if (tail_meta.is_store || tail_meta.err) push_data = '0;
    push = tail_meta.valid;
  end

  // The queue cannot overflow: everything in the pipe or queue is counted in outstanding_reg.
  logic [33:0]      q_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] q_count_reg;
  logic [33:0]      head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (push) q_mem[wr_ptr_reg] <= {tail_meta.is_store, tail_meta.err, push_data};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      q_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   q_count_reg <= q_count_reg + CNT_W'(1);
        2'b01:   q_count_reg <= q_count_reg - CNT_W'(1);
        default: q_count_reg <= q_count_reg;
      endcase
    end
  end

  assign head          = q_mem[rd_ptr_reg];
  assign resp_valid    = (q_count_reg != '0);
  assign resp_rdata    = resp_valid ? head[31:0] : '0;
  assign resp_err      = resp_valid && head[32];
  assign resp_is_store = resp_valid && head[33];

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe: randomized traffic against a byte-array model with an
// in-order expected-response queue; directed scenarios for extension, backpressure, alignment and reset.
`timescale 1ns/1ps
module tb_dmem_pipe;
  localparam int ADDR_W    = 10;
  localparam int LATENCY   = 2;
  localparam int MAX_OUT   = 4;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic        CLK, RST;
  logic        req_valid, req_ready, req_we, req_sext;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err, resp_is_store;
  logic [31:0] resp_rdata;

  dmem_pipe #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_sext(req_sext), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_is_store(resp_is_store)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        err;
    logic        st;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [MEM_BYTES];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic        t_acc, t_pop, t_rv, t_rdy, t_re, t_rs;
  logic [31:0] t_rd;
  int          t_rc;

  // Reference behaviour: bytes in a flat array, little-endian assembly, extension by subtracting 2^n.
  function automatic exp_t model_apply(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                       input logic sext, input logic [31:0] wdata);
    exp_t        e;
    int          nbytes;
    int          a;
    logic [31:0] v;
    nbytes    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.st      = we;
    e.err     = (addr >= MEM_BYTES);
    e.data    = '0;
    e.acc_cyc = cyc;
    a         = int'(addr[ADDR_W-1:0]);
`ifdef DMEM_ALIGN_TRAP_EN
    if ((int'(addr[1:0]) % nbytes) != 0) e.err = 1'b1;
`else
    a = a - (a % nbytes);
`endif
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) model_mem[a+i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(model_mem[a+i]) << (8*i));
        if (sext && nbytes < 4 && v[8*nbytes-1]) v = v - (32'd1 << (8*nbytes));
        e.data = v;
      end
    end
    return e;
  endfunction

  // Drive one cycle from a falling edge, sample what the coming rising edge will do, advance.
  task automatic tick(input logic v, input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic sx, input logic [31:0] wd, input logic rr);
    req_valid = v; req_we = we; req_addr = a; req_size = sz; req_sext = sx; req_wdata = wd;
    resp_ready = rr;
    #1;
    t_rdy = req_ready;
    t_rv  = resp_valid;
    t_acc = req_valid && req_ready;
    t_pop = resp_valid && resp_ready;
    t_rd  = resp_rdata;
    t_re  = resp_err;
    t_rs  = resp_is_store;
    t_rc  = cyc;
    if (t_acc) exp_q.push_back(model_apply(we, a, sz, sx, wd));
    @(negedge CLK);
    cyc++;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_sext = 0; req_wdata = 0; resp_ready = 0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
    n_checks++;
    if ({resp_rdata, resp_err, resp_is_store} !== 34'd0) begin
      n_errors++;
      $display("FAIL reset_resp_fields got rdata=%08h err=%0b st=%0b want 0", resp_rdata, resp_err, resp_is_store);
    end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready got %0b want 1", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_store_load;
    exp_t e;
    int   st_pop = -100;
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      tick(1, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 1);
      else if (i == 1) tick(1, 0, 32'h10, 2'b10, 0, 32'h0, 1);
      else             tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (i < 2) begin
        n_checks++;
        if (t_acc !== 1'b1) begin n_errors++; $display("FAIL st_ld_accept[%0d] got %0b want 1", i, t_acc); end
      end
      if (t_pop) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== {e.err, e.st, e.data}) begin
          n_errors++;
          $display("FAIL st_ld_resp got err=%0b st=%0b data=%08h want err=%0b st=%0b data=%08h",
                   t_re, t_rs, t_rd, e.err, e.st, e.data);
        end
        if (e.st) st_pop = t_rc;
        else begin
          n_checks++;
          if ((t_rc - e.acc_cyc) != LATENCY + 1 || t_rc != st_pop + 1) begin
            n_errors++;
            $display("FAIL st_ld_timing got lat=%0d gap=%0d want lat=%0d gap=1",
                     t_rc - e.acc_cyc - 1, t_rc - st_pop, LATENCY);
          end
        end
        $display("st_ld resp cyc=%0d err=%0b st=%0b data=%08h", t_rc, t_re, t_rs, t_rd);
      end
      if (i >= 2 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL st_ld_timeout got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_extension;
    logic [31:0] want [3];
    exp_t        e;
    int          k = 0;
    want = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      tick(1, 0, 32'h13, 2'b00, 1, 32'h0, 1);
      else if (i == 1) tick(1, 0, 32'h13, 2'b00, 0, 32'h0, 1);
      else if (i == 2) tick(1, 0, 32'h12, 2'b01, 1, 32'h0, 1);
      else             tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (t_pop && k < 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== {2'b00, want[k]}) begin
          n_errors++;
          $display("FAIL ext[%0d] got err=%0b st=%0b data=%08h want err=0 st=0 data=%08h", k, t_re, t_rs, t_rd, want[k]);
        end
        $display("ext resp %0d data=%08h", k, t_rd);
        k++;
      end
      if (i >= 3 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (k != 3) begin n_errors++; $display("FAIL ext_count got %0d want 3", k); end
  endtask

  task automatic test_backpressure;
    exp_t        e;
    int          n_acc = 0;
    logic        have_held = 0;
    logic [33:0] held = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 32'h10 + 32'(n_acc % 4), 2'b00, 0, 32'h0, 0);
      if (t_acc) n_acc++;
      if (t_rv) begin
        if (!have_held) begin held = {t_re, t_rs, t_rd}; have_held = 1; end
        else begin
          n_checks++;
          if ({t_re, t_rs, t_rd} !== held) begin
            n_errors++;
            $display("FAIL bp_hold got %09h want %09h", {t_re, t_rs, t_rd}, held);
          end
        end
      end
    end
    n_checks++;
    if (n_acc != MAX_OUT) begin n_errors++; $display("FAIL bp_accepts got %0d want %0d", n_acc, MAX_OUT); end
    n_checks++;
    if (req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_low got %0b want 0", req_ready); end
    req_valid = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (t_pop) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== {e.err, e.st, e.data}) begin
          n_errors++;
          $display("FAIL bp_resp got err=%0b st=%0b data=%08h want err=%0b st=%0b data=%08h",
                   t_re, t_rs, t_rd, e.err, e.st, e.data);
        end
        $display("bp resp cyc=%0d data=%08h", t_rc, t_rd);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_drain got pending=%0d ready=%0b want pending=0 ready=1", exp_q.size(), req_ready);
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    int          n_acc = 0, n_pop = 0, prev = -100;
    logic        gap_ok = 1;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        sx;
    for (int i = 0; i < 16 + LATENCY + 10; i++) begin
      a  = 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      if (i < 16) tick(1, 0, a, sz, sx, 32'h0, 1);
      else        tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (i < 16 && t_acc) n_acc++;
      if (t_pop) begin
        if (n_pop > 0 && t_rc != prev + 1) gap_ok = 0;
        prev = t_rc;
        n_pop++;
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== {e.err, e.st, e.data}) begin
          n_errors++;
          $display("FAIL b2b_resp[%0d] got err=%0b st=%0b data=%08h want err=%0b st=%0b data=%08h",
                   n_pop - 1, t_re, t_rs, t_rd, e.err, e.st, e.data);
        end
        $display("b2b resp %0d cyc=%0d data=%08h", n_pop - 1, t_rc, t_rd);
      end
    end
    n_checks++;
    if (n_acc != 16) begin n_errors++; $display("FAIL b2b_accepts got %0d want 16", n_acc); end
    n_checks++;
    if (n_pop != 16 || !gap_ok) begin
      n_errors++;
      $display("FAIL b2b_responses got n=%0d consecutive=%0b want n=16 consecutive=1", n_pop, gap_ok);
    end
  endtask

  task automatic test_align;
    logic [33:0] want [4];
    exp_t        e;
    int          k = 0;
`ifdef DMEM_ALIGN_TRAP_EN
    want = '{{2'b11, 32'h0}, {2'b10, 32'h0}, {2'b00, 32'hDEADBEEF}, {2'b10, 32'h0}};
`else
    want = '{{2'b01, 32'h0}, {2'b00, 32'hCAFEF00D}, {2'b00, 32'hCAFEF00D}, {2'b10, 32'h0}};
`endif
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      tick(1, 1, 32'h11, 2'b10, 0, 32'hCAFEF00D, 1);
      else if (i == 1) tick(1, 0, 32'h11, 2'b10, 0, 32'h0, 1);
      else if (i == 2) tick(1, 0, 32'h10, 2'b10, 0, 32'h0, 1);
      else if (i == 3) tick(1, 0, 32'(MEM_BYTES), 2'b10, 0, 32'h0, 1);
      else             tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (t_pop && k < 4) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== want[k]) begin
          n_errors++;
          $display("FAIL align[%0d] got err=%0b st=%0b data=%08h want err=%0b st=%0b data=%08h",
                   k, t_re, t_rs, t_rd, want[k][33], want[k][32], want[k][31:0]);
        end
        $display("align resp %0d err=%0b data=%08h", k, t_re, t_rd);
        k++;
      end
      if (i >= 4 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (k != 4) begin n_errors++; $display("FAIL align_count got %0d want 4", k); end
  endtask

  task automatic test_random;
    exp_t        e;
    int          sz_before;
    logic        v, we, sx, rr;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    for (int i = 0; i < 16 + 200 + 40; i++) begin
      sz_before = exp_q.size();
      if (i < 16) tick(1, 1, 32'(4 * i), 2'b10, 0, $urandom, 1);
      else if (i < 216) begin
        v  = ($urandom_range(0, 9) < 8);
        we = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 15) == 0) ? 32'(MEM_BYTES) + 32'($urandom_range(0, 4095))
                                          : 32'($urandom_range(0, 63));
        sz = 2'($urandom_range(0, 3));
        sx = 1'($urandom_range(0, 1));
        wd = $urandom;
        rr = ($urandom_range(0, 9) < 7);
        tick(v, we, a, sz, sx, wd, rr);
      end else tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      n_checks++;
      if (t_rdy !== (sz_before < MAX_OUT)) begin
        n_errors++;
        $display("FAIL rand_ready cyc=%0d got %0b want %0b", t_rc, t_rdy, (sz_before < MAX_OUT));
      end
      if (t_pop) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== {e.err, e.st, e.data}) begin
          n_errors++;
          $display("FAIL rand_resp cyc=%0d got err=%0b st=%0b data=%08h want err=%0b st=%0b data=%08h",
                   t_rc, t_re, t_rs, t_rd, e.err, e.st, e.data);
        end
        $display("rand resp cyc=%0d err=%0b st=%0b data=%08h", t_rc, t_re, t_rs, t_rd);
      end
      if (i >= 216 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   stale = 0;
    int   n_ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) tick(1, 1, 32'h20, 2'b10, 0, 32'h13579BDF, 1);
      else        tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (t_pop) void'(exp_q.pop_front());
      if (i >= 1 && exp_q.size() == 0) break;
    end
    for (int i = 0; i < 3; i++) tick(1, 0, 32'h20 + 32'(i), 2'b00, 0, 32'h0, 0);
    n_checks++;
    if (exp_q.size() != 3) begin n_errors++; $display("FAIL rst_mid_outstanding got %0d want 3", exp_q.size()); end
    req_valid = 0;
    RST = 1'b1;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs got valid=%0b ready=%0b want 0 0", resp_valid, req_ready);
    end
    exp_q.delete();
    repeat (2) @(negedge CLK);
    cyc += 2;
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (t_rv) stale++;
    end
    n_checks++;
    if (stale != 0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_after got stale=%0d ready=%0b want stale=0 ready=1", stale, req_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 0) tick(1, 0, 32'h20, 2'b10, 0, 32'h0, 1);
      else        tick(0, 0, 32'h0, 2'b00, 0, 32'h0, 1);
      if (t_pop) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({t_re, t_rs, t_rd} !== {2'b00, 32'h13579BDF}) begin
          n_errors++;
          $display("FAIL rst_mid_keep got err=%0b st=%0b data=%08h want err=0 st=0 data=13579bdf", t_re, t_rs, t_rd);
        end else n_ok++;
        $display("rst_mid resp data=%08h", t_rd);
      end
      if (i >= 1 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (n_ok != 1) begin n_errors++; $display("FAIL rst_mid_readback got %0d good responses want 1", n_ok); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extension();
    test_backpressure();
    test_back_to_back();
    test_align();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
